mat_loader: RTL and testbench

- Upstream feeder for the element-wise matrix adder.
- Accepts a single valid/ready stream of DW-bit elements. Assembles operand matrix A, then operand matrix B, each in row-major order.
- Presents both matrices as flat buses with an enable level, then holds them stable until the adder reports done or a watchdog expires.
- Frames the stream with s_last and rejects mis-sized frames.

---
 rtl/mat_loader_if.sv | 30 +++
 rtl/mat_loader.sv | 101 ++++++++++
 tb/tb_mat_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mat_loader_if.sv
// Stream-in / operand-out bundle between the element feeder, mat_loader and the matrix adder.
interface mat_loader_if #(
    parameter int RSIZE = 2,
    parameter int CSIZE = 3,
    parameter int DW    = 32
);
    localparam int MW = RSIZE * CSIZE * DW;

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic [MW-1:0] mat_a;
    logic [MW-1:0] mat_b;
    logic          en;
    logic          done;
    logic          err;
    logic          timeout;
    logic [15:0]   frame_cnt;

    modport master (
        output s_valid, s_data, s_last, done,
        input  s_ready, mat_a, mat_b, en, err, timeout, frame_cnt
    );

    modport slave (
        input  s_valid, s_data, s_last, done,
        output s_ready, mat_a, mat_b, en, err, timeout, frame_cnt
    );
endinterface

// File: rtl/mat_loader.sv
// Collects operand matrices A then B from one element stream and holds them for the adder
// until it reports done or the watchdog expires.
//
// state  | meaning
// LOAD_A | accepting beats 0..N-1 into mat_a
// LOAD_B | accepting beats N..2N-1 into mat_b, s_last expected on the final beat
// ISSUE  | en high, operands frozen, waiting for done or watchdog
module mat_loader #(
    parameter int RSIZE   = 2,
    parameter int CSIZE   = 3,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    mat_loader_if.slave  bus
);
    localparam int N  = RSIZE * CSIZE;
    localparam int MW = N * DW;
    localparam int CW = $clog2(2 * N);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        ISSUE  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   beat_cnt;
    logic [WW-1:0]   wait_cnt;
    logic            is_final;
    logic            issue_entry;

    assign bus.s_ready = (state != ISSUE);
    assign is_final    = (beat_cnt == CW'(2 * N - 1));
    // Watchdog counts down from TIMEOUT-1, so the full value marks the first ISSUE cycle.
    assign issue_entry = (wait_cnt == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= LOAD_A;
            beat_cnt      <= '0;
            wait_cnt      <= '0;
            bus.mat_a     <= '0;
            bus.mat_b     <= '0;
            bus.en        <= 1'b0;
            bus.err       <= 1'b0;
            bus.timeout   <= 1'b0;
            bus.frame_cnt <= '0;
        end else begin
            bus.err     <= 1'b0;
            bus.timeout <= 1'b0;
            case (state)
                LOAD_A, LOAD_B: begin
                    if (bus.s_valid) begin
                        for (int i = 0; i < N; i++) begin
                            if (state == LOAD_A && beat_cnt == CW'(i))
                                bus.mat_a[i*DW +: DW] <= bus.s_data;
                            if (state == LOAD_B && beat_cnt == CW'(N + i))
                                bus.mat_b[i*DW +: DW] <= bus.s_data;
                        end
                        if (bus.s_last != is_final) begin
                            bus.err  <= 1'b1;
                            beat_cnt <= '0;
                            state    <= LOAD_A;
                        end else if (is_final) begin
                            beat_cnt <= '0;
                            wait_cnt <= WW'(TIMEOUT - 1);
                            bus.en   <= 1'b1;
                            state    <= ISSUE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            if (beat_cnt == CW'(N - 1))
                                state <= LOAD_B;
                        end
                    end
                end
                ISSUE: begin
                    // A done still high from the previous frame is masked on entry.
                    if (bus.done && !issue_entry) begin
                        bus.en        <= 1'b0;
                        bus.frame_cnt <= bus.frame_cnt + 16'd1;
                        state         <= LOAD_A;
                    end else if (wait_cnt == '0) begin
                        bus.en      <= 1'b0;
                        bus.timeout <= 1'b1;
                        state       <= LOAD_A;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: begin
                    bus.en   <= 1'b0;
                    beat_cnt <= '0;
                    state    <= LOAD_A;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mat_loader.sv
// Directed plus randomized bench for mat_loader against an element-array reference model.
module tb_mat_loader;
    localparam int RSIZE   = 2;
    localparam int CSIZE   = 3;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;
    localparam int N       = RSIZE * CSIZE;
    localparam int MW      = N * DW;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [DW-1:0] exp_a [N];
    logic [DW-1:0] exp_b [N];
    int            k_model;
    logic [15:0]   exp_fc;

    mat_loader_if #(.RSIZE(RSIZE), .CSIZE(CSIZE), .DW(DW)) bus ();

    mat_loader #(.RSIZE(RSIZE), .CSIZE(CSIZE), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MW-1:0] pack_a();
        logic [MW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = exp_a[i];
        return v;
    endfunction

    function automatic logic [MW-1:0] pack_b();
        logic [MW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = exp_b[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            exp_a[i] = '0;
            exp_b[i] = '0;
        end
        k_model = 0;
        exp_fc  = '0;
    endtask

    // Offer one element after `gap` idle cycles; done toggles randomly while loading.
    task automatic send_beat(input logic [DW-1:0] d, input bit last, input int gap);
        int n;
        bit exp_err;
        bit exp_issue;
        bus.s_valid = 1'b0;
        repeat (gap) begin
            bus.done = 1'($urandom_range(0, 1));
            tick();
        end
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        n = 0;
        while (bus.s_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("s_ready_before_beat", MW'(bus.s_ready), MW'(1));
        if (k_model < N) exp_a[k_model] = d;
        else             exp_b[k_model - N] = d;
        exp_err   = (last != (k_model == 2 * N - 1));
        exp_issue = !exp_err && (k_model == 2 * N - 1);
        k_model   = (exp_err || exp_issue) ? 0 : k_model + 1;
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.done    = 1'b0;
        chk("err_after_beat", MW'(bus.err), MW'(exp_err));
        chk("en_after_beat", MW'(bus.en), MW'(exp_issue));
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input bit rnd, input int gapmax);
        for (int i = 0; i < 2 * N; i++)
            send_beat(rnd ? DW'($urandom) : base + DW'(i), (i == 2 * N - 1), $urandom_range(0, gapmax));
        chk("mat_a_loaded", bus.mat_a, pack_a());
        chk("mat_b_loaded", bus.mat_b, pack_b());
    endtask

    // Called on the first ISSUE cycle. done is raised in ISSUE cycle index done_at
    // (0 = entry cycle); the stream keeps offering data that must not be taken.
    task automatic run_issue(input int done_at, input bit entry_done);
        int cnt;
        int exp_cnt;
        int rdy_bad;
        bit hit;
        hit     = (done_at >= 1) && (done_at <= TIMEOUT - 1);
        exp_cnt = hit ? done_at + 1 : TIMEOUT;
        cnt     = 0;
        rdy_bad = 0;
        while (bus.en === 1'b1 && cnt < 100) begin
            if (bus.s_ready !== 1'b0) rdy_bad++;
            bus.s_valid = 1'b1;
            bus.s_data  = DW'($urandom);
            bus.done    = (cnt == done_at) || (cnt == 0 && entry_done);
            tick();
            cnt++;
        end
        bus.s_valid = 1'b0;
        bus.done    = 1'b0;
        if (hit) exp_fc++;
        chk("en_high_cycles", MW'(cnt), MW'(exp_cnt));
        chk("s_ready_low_in_issue", MW'(rdy_bad), MW'(0));
        chk("timeout_pulse", MW'(bus.timeout), MW'(!hit));
        chk("frame_cnt", MW'(bus.frame_cnt), MW'(exp_fc));
        chk("mat_a_frozen", bus.mat_a, pack_a());
        chk("mat_b_frozen", bus.mat_b, pack_b());
        chk("s_ready_after_issue", MW'(bus.s_ready), MW'(1));
        tick();
        chk("timeout_cleared", MW'(bus.timeout), MW'(0));
    endtask

    initial begin
        logic [DW-1:0] x;
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.done    = 1'b0;
        model_reset();
        repeat (3) tick();

        chk("rst_s_ready", MW'(bus.s_ready), MW'(1));
        chk("rst_en", MW'(bus.en), MW'(0));
        chk("rst_mat_a", bus.mat_a, MW'(0));
        chk("rst_mat_b", bus.mat_b, MW'(0));
        chk("rst_frame_cnt", MW'(bus.frame_cnt), MW'(0));
        chk("rst_err", MW'(bus.err), MW'(0));
        chk("rst_timeout", MW'(bus.timeout), MW'(0));
        rst_n = 1'b1;
        tick();

        // Frame 1..12 back to back, done three cycles after en rises.
        send_frame(DW'(1), 1'b0, 0);
        chk("a_elem_1_2", MW'(bus.mat_a[(1*CSIZE+2)*DW +: DW]), MW'(6));
        chk("b_elem_0_0", MW'(bus.mat_b[0 +: DW]), MW'(7));
        run_issue(3, 1'b0);

        // Early s_last on beat 5, then a clean frame 21..32.
        for (int i = 0; i < 4; i++) send_beat(DW'($urandom), 1'b0, 0);
        send_beat(DW'($urandom), 1'b1, 0);
        tick();
        chk("err_one_cycle", MW'(bus.err), MW'(0));
        chk("en_after_err", MW'(bus.en), MW'(0));
        send_frame(DW'(21), 1'b0, 1);
        chk("a_elem_0_0_is_21", MW'(bus.mat_a[0 +: DW]), MW'(21));
        run_issue(1, 1'b0);

        // Missing s_last on beat 12; the next beat restarts mat_a.
        for (int i = 0; i < 2 * N; i++) send_beat(DW'($urandom), 1'b0, 0);
        x = DW'($urandom);
        send_beat(x, 1'b0, 0);
        chk("restart_a_elem_0_0", MW'(bus.mat_a[0 +: DW]), MW'(x));
        for (int i = 1; i < 2 * N; i++) send_beat(DW'($urandom), (i == 2 * N - 1), 0);
        chk("restart_mat_a", bus.mat_a, pack_a());
        chk("restart_mat_b", bus.mat_b, pack_b());
        run_issue(TIMEOUT - 1, 1'b0);

        // Watchdog: done only on the entry cycle, otherwise held low.
        send_frame('0, 1'b1, 0);
        run_issue(-1, 1'b1);

        // Reset in the middle of LOAD_B.
        for (int i = 0; i < N + 2; i++) send_beat(DW'($urandom), 1'b0, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_mat_a", bus.mat_a, MW'(0));
        chk("async_rst_mat_b", bus.mat_b, MW'(0));
        chk("async_rst_en", MW'(bus.en), MW'(0));
        chk("async_rst_s_ready", MW'(bus.s_ready), MW'(1));
        chk("async_rst_frame_cnt", MW'(bus.frame_cnt), MW'(0));
        tick();
        rst_n = 1'b1;
        tick();
        send_frame('0, 1'b1, 3);
        run_issue(2, 1'b0);

        for (int f = 0; f < 6; f++) begin
            send_frame('0, 1'b1, 3);
            run_issue($urandom_range(1, TIMEOUT + 4), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
